// File: rtl/trace_lockstep_checker.sv
// trace_lockstep_checker
// Compares one reference retirement-trace stream against NDUT DUT streams in
// order. Each stream is buffered in its own skew FIFO. The checker latches the
// first divergence, a push into a full FIFO, or a stall timeout, and then halts
// until reset or clear.
// Optional build macro: TRACE_CHECK_MASK_EN adds cmp_mask, which restricts the
// equality test to the bits set in the mask.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | accepting beats, comparing FIFO heads, counting stall cycles
// ST_HALT | error latched; FIFOs and outputs frozen until reset/clear
`default_nettype none

module trace_lockstep_checker #(
    parameter int WIDTH   = 36,
    parameter int NDUT    = 1,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
`ifdef TRACE_CHECK_MASK_EN
    input  logic [WIDTH-1:0]      cmp_mask,
`endif
    input  logic                  ref_valid,
    input  logic [WIDTH-1:0]      ref_data,
    input  logic [NDUT-1:0]       dut_valid,
    input  logic [NDUT*WIDTH-1:0] dut_data,
    output logic [31:0]           compared_count,
    output logic                  mismatch,
    output logic [NDUT-1:0]       mismatch_mask,
    output logic [WIDTH-1:0]      first_ref_data,
    output logic [WIDTH-1:0]      first_dut_data,
    output logic                  overflow,
    output logic                  timeout,
    output logic                  halted
);

    // Stream 0 is the reference; streams 1..NDUT are the DUTs.
    localparam int NS = NDUT + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STALL_LIMIT = SW'(TIMEOUT);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_mem  [NS][DEPTH];
    logic [PW-1:0]    r_wptr [NS];
    logic [PW-1:0]    r_rptr [NS];

    logic [31:0]       r_count;
    logic              r_mismatch;
    logic [NDUT-1:0]   r_mask;
    logic [WIDTH-1:0]  r_first_ref;
    logic [WIDTH-1:0]  r_first_dut;
    logic              r_overflow;
    logic              r_timeout;
    logic [SW-1:0]     r_stall;

    logic [NS-1:0]     w_valid;
    logic [NS-1:0]     w_empty;
    logic [NS-1:0]     w_full;
    logic [NS-1:0]     w_push;
    logic [NS-1:0]     w_ovf;
    logic [WIDTH-1:0]  w_din  [NS];
    logic [WIDTH-1:0]  w_head [NS];
    logic [WIDTH-1:0]  w_cmp_mask;
    logic [NDUT-1:0]   w_diff;
    logic [WIDTH-1:0]  w_first_dut;
    logic [SW-1:0]     w_stall_next;
    logic              w_run;
    logic              w_all_empty;
    logic              w_compare;
    logic              w_mismatch_evt;
    logic              w_overflow_evt;
    logic              w_timeout_evt;

`ifdef TRACE_CHECK_MASK_EN
    assign w_cmp_mask = cmp_mask;
`else
    assign w_cmp_mask = '1;
`endif

    assign w_valid     = {dut_valid, ref_valid};
    assign w_run       = (r_state == ST_RUN);
    assign w_all_empty = &w_empty;
    assign w_compare   = w_run && (w_empty == '0);

    // Unpack the per-stream beat inputs into one array indexed by stream.
    always_comb begin
        w_din[0] = ref_data;
        for (int i = 0; i < NDUT; i++) begin
            w_din[i+1] = dut_data[i*WIDTH +: WIDTH];
        end
    end

    // FIFO status and head words. Full and empty come from the pointer MSB wrap.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            w_empty[s] = (r_wptr[s] == r_rptr[s]);
            w_full[s]  = (r_wptr[s][PW-1] != r_rptr[s][PW-1]) &&
                         (r_wptr[s][AW-1:0] == r_rptr[s][AW-1:0]);
            w_head[s]  = r_mem[s][r_rptr[s][AW-1:0]];
        end
    end

    // Push acceptance. A full FIFO takes the push when it is popped in the same
    // cycle. Otherwise the beat is dropped and an overflow is raised.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            w_push[s] = w_run && w_valid[s] && (!w_full[s] || w_compare);
            w_ovf[s]  = w_run && w_valid[s] &&  w_full[s] && !w_compare;
        end
    end

    assign w_overflow_evt = |w_ovf;

    // Compare each DUT head against the reference head under the compare mask.
    // The lowest-indexed differing DUT supplies the captured DUT word.
    always_comb begin
        w_diff      = '0;
        w_first_dut = w_head[1];
        for (int i = 0; i < NDUT; i++) begin
            w_diff[i] = |((w_head[0] ^ w_head[i+1]) & w_cmp_mask);
        end
        for (int i = NDUT - 1; i >= 0; i--) begin
            if (w_diff[i]) begin
                w_first_dut = w_head[i+1];
            end
        end
    end

    assign w_mismatch_evt = w_compare && (w_diff != '0);

    // Stall counter next value. It restarts on any compare or when every FIFO
    // has drained.
    always_comb begin
        w_stall_next = r_stall + SW'(1);
        if (w_compare || w_all_empty) begin
            w_stall_next = '0;
        end
    end

    assign w_timeout_evt = w_run && (w_stall_next == STALL_LIMIT);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state. Any error leaves RUN. Only clear (or reset) leaves HALT.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_mismatch_evt || w_overflow_evt || w_timeout_evt) begin
                    w_state_next = ST_HALT;
                end
            end
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_RUN;
        endcase
        if (clear) begin
            w_state_next = ST_RUN;
        end
    end

    // FIFO storage. Storage is not reset; the pointers alone define the contents.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NS; s++) begin
            if (w_push[s]) begin
                r_mem[s][r_wptr[s][AW-1:0]] <= w_din[s];
            end
        end
    end

    // FIFO pointers. All heads pop together on a compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                r_wptr[s] <= '0;
                r_rptr[s] <= '0;
            end
        end else if (clear) begin
            for (int s = 0; s < NS; s++) begin
                r_wptr[s] <= '0;
                r_rptr[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (w_push[s]) begin
                    r_wptr[s] <= r_wptr[s] + PW'(1);
                end
                if (w_compare) begin
                    r_rptr[s] <= r_rptr[s] + PW'(1);
                end
            end
        end
    end

    // Result, sticky-flag and stall registers. These update only in RUN, so
    // HALT freezes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_mismatch  <= 1'b0;
            r_mask      <= '0;
            r_first_ref <= '0;
            r_first_dut <= '0;
            r_overflow  <= 1'b0;
            r_timeout   <= 1'b0;
            r_stall     <= '0;
        end else if (clear) begin
            r_count     <= '0;
            r_mismatch  <= 1'b0;
            r_mask      <= '0;
            r_first_ref <= '0;
            r_first_dut <= '0;
            r_overflow  <= 1'b0;
            r_timeout   <= 1'b0;
            r_stall     <= '0;
        end else if (w_run) begin
            r_stall <= w_stall_next;
            if (w_compare && !w_mismatch_evt && (r_count != 32'hFFFF_FFFF)) begin
                r_count <= r_count + 32'd1;
            end
            if (w_mismatch_evt) begin
                r_mismatch  <= 1'b1;
                r_mask      <= w_diff;
                r_first_ref <= w_head[0];
                r_first_dut <= w_first_dut;
            end
            if (w_overflow_evt) begin
                r_overflow <= 1'b1;
            end
            if (w_timeout_evt) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign compared_count = r_count;
    assign mismatch       = r_mismatch;
    assign mismatch_mask  = r_mask;
    assign first_ref_data = r_first_ref;
    assign first_dut_data = r_first_dut;
    assign overflow       = r_overflow;
    assign timeout        = r_timeout;
    assign halted         = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_trace_lockstep_checker.sv
// Directed bench for trace_lockstep_checker. Instance u_a uses NDUT=1 and
// instance u_b uses NDUT=2. Both instances use DEPTH=16 and TIMEOUT=1024.
module tb_trace_lockstep_checker;

    localparam int W = 36;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [W-1:0] cmp_mask;

    logic          a_clear, a_ref_valid;
    logic [W-1:0]  a_ref_data;
    logic [0:0]    a_dut_valid;
    logic [W-1:0]  a_dut_data;
    logic [31:0]   a_count;
    logic          a_mismatch, a_overflow, a_timeout, a_halted;
    logic [0:0]    a_mask;
    logic [W-1:0]  a_first_ref, a_first_dut;

    logic          b_clear, b_ref_valid;
    logic [W-1:0]  b_ref_data;
    logic [1:0]    b_dut_valid;
    logic [2*W-1:0] b_dut_data;
    logic [31:0]   b_count;
    logic          b_mismatch, b_overflow, b_timeout, b_halted;
    logic [1:0]    b_mask;
    logic [W-1:0]  b_first_ref, b_first_dut;

    trace_lockstep_checker #(.WIDTH(W), .NDUT(1), .DEPTH(16), .TIMEOUT(1024)) u_a (
        .clk(clk), .reset(reset), .clear(a_clear),
`ifdef TRACE_CHECK_MASK_EN
        .cmp_mask(cmp_mask),
`endif
        .ref_valid(a_ref_valid), .ref_data(a_ref_data),
        .dut_valid(a_dut_valid), .dut_data(a_dut_data),
        .compared_count(a_count), .mismatch(a_mismatch), .mismatch_mask(a_mask),
        .first_ref_data(a_first_ref), .first_dut_data(a_first_dut),
        .overflow(a_overflow), .timeout(a_timeout), .halted(a_halted)
    );

    trace_lockstep_checker #(.WIDTH(W), .NDUT(2), .DEPTH(16), .TIMEOUT(1024)) u_b (
        .clk(clk), .reset(reset), .clear(b_clear),
`ifdef TRACE_CHECK_MASK_EN
        .cmp_mask(cmp_mask),
`endif
        .ref_valid(b_ref_valid), .ref_data(b_ref_data),
        .dut_valid(b_dut_valid), .dut_data(b_dut_data),
        .compared_count(b_count), .mismatch(b_mismatch), .mismatch_mask(b_mask),
        .first_ref_data(b_first_ref), .first_dut_data(b_first_dut),
        .overflow(b_overflow), .timeout(b_timeout), .halted(b_halted)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_ref_valid = 1'b0;
        a_dut_valid = 1'b0;
    endtask

    task automatic a_do_clear();
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
    endtask

    task automatic b_idle();
        b_ref_valid = 1'b0;
        b_dut_valid = 2'b00;
    endtask

    initial begin
        reset       = 1'b1;
        cmp_mask    = '1;
        a_clear     = 1'b0; a_ref_valid = 1'b0; a_ref_data = '0; a_dut_valid = 1'b0; a_dut_data = '0;
        b_clear     = 1'b0; b_ref_valid = 1'b0; b_ref_data = '0; b_dut_valid = 2'b00; b_dut_data = '0;
        tick();
        tick();

        // Reset state
        check("rst_a_count",     64'(a_count),     64'd0);
        check("rst_a_mismatch",  64'(a_mismatch),  64'd0);
        check("rst_a_mask",      64'(a_mask),      64'd0);
        check("rst_a_first_ref", 64'(a_first_ref), 64'd0);
        check("rst_a_first_dut", 64'(a_first_dut), 64'd0);
        check("rst_a_overflow",  64'(a_overflow),  64'd0);
        check("rst_a_timeout",   64'(a_timeout),   64'd0);
        check("rst_a_halted",    64'(a_halted),    64'd0);
        check("rst_b_halted",    64'(b_halted),    64'd0);
        reset = 1'b0;
        tick();

        // 100 identical beats, same cycle on both streams
        for (int i = 0; i < 100; i++) begin
            a_ref_valid = 1'b1; a_ref_data = W'(i);
            a_dut_valid = 1'b1; a_dut_data = W'(i);
            tick();
        end
        a_idle();
        tick();
        tick();
        check("same_cycle_count",    64'(a_count),    64'd100);
        check("same_cycle_mismatch", 64'(a_mismatch), 64'd0);
        check("same_cycle_halted",   64'(a_halted),   64'd0);

        // DUT lags the reference by 8 cycles
        a_do_clear();
        check("clear_count", 64'(a_count), 64'd0);
        for (int c = 0; c < 20; c++) begin
            a_ref_valid = (c < 10);
            a_ref_data  = W'(c + 1);
            a_dut_valid = (c >= 8 && c < 18);
            a_dut_data  = W'(c - 7);
            tick();
            if (c == 8) check("skew_before_compare", 64'(a_count), 64'd0);
            if (c == 9) check("skew_first_compare",  64'(a_count), 64'd1);
        end
        a_idle();
        tick();
        check("skew_count",    64'(a_count),    64'd10);
        check("skew_overflow", 64'(a_overflow), 64'd0);
        check("skew_mismatch", 64'(a_mismatch), 64'd0);
        check("skew_timeout",  64'(a_timeout),  64'd0);

        // Full reference FIFO popped and pushed in the same cycle
        a_do_clear();
        for (int c = 0; c < 17; c++) begin
            a_ref_valid = 1'b1;
            a_ref_data  = W'(32'h200 + c);
            a_dut_valid = (c == 15);
            a_dut_data  = W'(32'h200);
            tick();
            if (c == 16) check("full_pop_no_overflow", 64'(a_overflow), 64'd0);
        end
        a_ref_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            a_dut_valid = 1'b1;
            a_dut_data  = W'(32'h201 + c);
            tick();
        end
        a_idle();
        tick();
        tick();
        check("full_pop_count",    64'(a_count),    64'd17);
        check("full_pop_mismatch", 64'(a_mismatch), 64'd0);
        check("full_pop_overflow", 64'(a_overflow), 64'd0);

        // Overflow: 17 reference beats while the DUT stays silent
        a_do_clear();
        for (int c = 0; c < 17; c++) begin
            a_ref_valid = 1'b1;
            a_ref_data  = W'(32'h300 + c);
            tick();
            if (c == 15) check("ovf_16th_push",   64'(a_overflow), 64'd0);
            if (c == 16) check("ovf_17th_push",   64'(a_overflow), 64'd1);
            if (c == 16) check("ovf_17th_halted", 64'(a_halted),   64'd1);
        end
        for (int c = 0; c < 2; c++) begin
            a_ref_valid = 1'b1; a_ref_data = W'(32'h77);
            a_dut_valid = 1'b1; a_dut_data = W'(32'h77);
            tick();
        end
        a_idle();
        tick();
        tick();
        check("halt_hold_overflow", 64'(a_overflow), 64'd1);
        check("halt_drop_count",    64'(a_count),    64'd0);
        a_do_clear();
        check("ovf_clear_overflow", 64'(a_overflow), 64'd0);
        check("ovf_clear_halted",   64'(a_halted),   64'd0);
        a_ref_valid = 1'b1; a_ref_data = W'(32'h55);
        a_dut_valid = 1'b1; a_dut_data = W'(32'h55);
        tick();
        a_idle();
        tick();
        tick();
        check("post_clear_count",    64'(a_count),    64'd1);
        check("post_clear_mismatch", 64'(a_mismatch), 64'd0);

        // Stall timeout, then an asynchronous reset in mid-run
        a_do_clear();
        a_ref_valid = 1'b1; a_ref_data = W'(32'h9);
        tick();
        a_idle();
        repeat (1023) tick();
        check("timeout_1023", 64'(a_timeout), 64'd0);
        check("halted_1023",  64'(a_halted),  64'd0);
        tick();
        check("timeout_1024",  64'(a_timeout),  64'd1);
        check("halted_1024",   64'(a_halted),   64'd1);
        check("timeout_noovf", 64'(a_overflow), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_timeout", 64'(a_timeout), 64'd0);
        check("async_rst_halted",  64'(a_halted),  64'd0);
        tick();
        reset = 1'b0;
        tick();

        // NDUT=2: DUT1 diverges at beat 5
        for (int c = 0; c < 10; c++) begin
            b_ref_valid = 1'b1;
            b_ref_data  = W'(32'h11E + c);
            b_dut_valid = 2'b11;
            b_dut_data  = {((c == 5) ? W'(32'h124) : W'(32'h11E + c)), W'(32'h11E + c)};
            tick();
            if (c == 5) check("b_mismatch_before", 64'(b_mismatch), 64'd0);
            if (c == 6) check("b_mismatch_edge",   64'(b_mismatch), 64'd1);
        end
        b_idle();
        tick();
        tick();
        check("b_count",     64'(b_count),     64'd5);
        check("b_mismatch",  64'(b_mismatch),  64'd1);
        check("b_mask",      64'(b_mask),      64'h2);
        check("b_first_ref", 64'(b_first_ref), 64'h123);
        check("b_first_dut", 64'(b_first_dut), 64'h124);
        check("b_halted",    64'(b_halted),    64'd1);
        check("b_overflow",  64'(b_overflow),  64'd0);

        // Both DUTs differ: the lowest index supplies first_dut_data
        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
        b_ref_valid = 1'b1; b_ref_data = W'(32'hA);
        b_dut_valid = 2'b11; b_dut_data = {W'(32'hC), W'(32'hB)};
        tick();
        b_idle();
        tick();
        tick();
        check("b2_mask",      64'(b_mask),      64'h3);
        check("b2_first_ref", 64'(b_first_ref), 64'hA);
        check("b2_first_dut", 64'(b_first_dut), 64'hB);
        check("b2_count",     64'(b_count),     64'd0);

`ifdef TRACE_CHECK_MASK_EN
        // Masked compare ignores bits [3:0]
        a_do_clear();
        cmp_mask = 36'hFFFFFFFF0;
        a_ref_valid = 1'b1; a_ref_data = 36'h12345678A;
        a_dut_valid = 1'b1; a_dut_data = 36'h123456785;
        tick();
        a_ref_data = 36'h10;
        a_dut_data = 36'h00;
        tick();
        a_idle();
        tick();
        tick();
        check("mask_count",     64'(a_count),     64'd1);
        check("mask_mismatch",  64'(a_mismatch),  64'd1);
        check("mask_first_ref", 64'(a_first_ref), 64'h10);
        cmp_mask = '1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
